// File: rtl/handshake_tx.sv
// FIFO-buffered 4-phase request/acknowledge transmitter into a foreign clock domain.
// Words are queued via a valid/ready port; the FSM presents each one on dout before raising req.
module handshake_tx #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // A word transfers on any rising edge where in_valid and in_ready are both high;
    // in_valid may be held across edges and in_data must be stable while in_valid is high.
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     req,
    output logic [WIDTH-1:0]         dout,
    input  logic                     ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic [3:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        REQ_HI = 4'b0100,
        REQ_LO = 4'b1000
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            req_next;
    logic            load;
    logic            push;
    logic            ack_s0;
    logic            ack_s1;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // in_ready looks only at the registered count, so a same-cycle pop cannot open a slot.
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        req_next   = req;
        load       = 1'b0;
        case (state)
            IDLE: begin
                req_next = 1'b0;
                if (count != '0) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                // One cycle of settling so dout is stable before req is seen.
                req_next   = 1'b1;
                state_next = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s1) begin
                    req_next   = 1'b0;
                    state_next = REQ_LO;
                end else begin
                    req_next = 1'b1;
                end
            end
            REQ_LO: begin
                req_next = 1'b0;
                if (!ack_s1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req    <= 1'b0;
            dout   <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ack_s0 <= 1'b0;
            ack_s1 <= 1'b0;
        end else begin
            state  <= state_next;
            req    <= req_next;
            ack_s0 <= ack;
            ack_s1 <= ack_s0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy and pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx: stimulus pushes expected words into exp_q,
// a receiver process drives ack and a monitor pops/compares on every req rise and fall.
module tb_handshake_tx;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_SETUP  = 4'b0010;
    localparam logic [3:0] S_REQ_HI = 4'b0100;
    localparam logic [3:0] S_REQ_LO = 4'b1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             req;
    logic [WIDTH-1:0] dout;
    logic             ack;
    logic [CW-1:0]    count;
    logic             busy;
    logic [3:0]       state_dbg;

    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               ack_mode;   // 0: ack = req delayed 3 cycles, 1: ack = ack_force
    logic             ack_force;
    logic [3:0]       req_hist;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    handshake_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .dout      (dout),
        .ack       (ack),
        .count     (count),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- receiver model ----------------
    initial begin
        ack      = 1'b0;
        req_hist = '0;
        forever begin
            @(posedge clk);
            #1;
            req_hist = {req_hist[2:0], req};
            ack      = (ack_mode == 0) ? req_hist[3] : ack_force;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic             prev;
        logic [WIDTH-1:0] cur;
        prev = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (req && !prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got word %0h, none expected", dout);
                    end else begin
                        cur = exp_q.pop_front();
                        check("rx_word", dout, cur);
                    end
                end
                if (!req && prev) begin
                    check("rx_hold_at_req_fall", dout, cur);
                end
                prev = req;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        logic r;
        bit   ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            r = in_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(w);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: word %0h never accepted, expected acceptance", w);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (state_dbg == s) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: state %0h, expected %0h within 100 cycles", name, state_dbg, s);
        end
    endtask

    task automatic wait_drained(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (count == '0 && !busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: count %0d busy %0d, expected drained", name, count, busy);
        end else begin
            tick();
            check({name, "_all_delivered"}, exp_q.size(), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ack_mode  = 0;
        ack_force = 1'b0;

        #12;
        check("rst_req", req, 1'b0);
        check("rst_dout", dout, 12'h000);
        check("rst_count", count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_state", state_dbg, S_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word and latency
        in_valid = 1'b1;
        in_data  = 12'hA5C;
        tick();
        exp_q.push_back(12'hA5C);
        in_valid = 1'b0;
        check("single_count_after_push", count, 1);
        check("single_req_edge0", req, 1'b0);
        check("single_dout_edge0", dout, 12'h000);
        tick();
        check("single_dout_edge1", dout, 12'hA5C);
        check("single_state_edge1", state_dbg, S_SETUP);
        check("single_req_edge1", req, 1'b0);
        check("single_count_edge1", count, 0);
        tick();
        check("single_req_edge2", req, 1'b1);
        check("single_state_edge2", state_dbg, S_REQ_HI);
        wait_drained("single");

        // Burst with a stalled receiver: fill to DEPTH, then a blocked push
        ack_mode  = 1;
        ack_force = 1'b0;
        for (int w = 1; w <= 5; w++) push_word(WIDTH'(w));
        check("burst_full_count", count, 4);
        check("burst_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 12'h006;
        repeat (3) tick();
        check("burst_full_ignored", count, 4);
        check("burst_stuck_state", state_dbg, S_REQ_HI);
        in_valid = 1'b0;
        ack_mode = 0;
        push_word(12'h006);
        wait_drained("burst");

        // Pointer wrap
        for (int w = 0; w < 10; w++) push_word(WIDTH'(w));
        wait_drained("wrap");

        // Early ack: ack held high before req rises
        ack_mode  = 1;
        ack_force = 1'b1;
        repeat (4) tick();
        check("ack_in_idle_state", state_dbg, S_IDLE);
        check("ack_in_idle_busy", busy, 1'b0);
        in_valid = 1'b1;
        in_data  = 12'h3C3;
        tick();
        exp_q.push_back(12'h3C3);
        in_valid = 1'b0;
        tick();
        check("early_setup_state", state_dbg, S_SETUP);
        tick();
        check("early_req_high", req, 1'b1);
        tick();
        check("early_req_one_cycle", req, 1'b0);
        check("early_state_req_lo", state_dbg, S_REQ_LO);
        repeat (3) tick();
        check("early_wait_ack_low", state_dbg, S_REQ_LO);
        ack_force = 1'b0;
        wait_drained("early");

        // Reset mid-transfer
        ack_mode  = 1;
        ack_force = 1'b0;
        push_word(12'hA11);
        push_word(12'hB22);
        push_word(12'hC33);
        check("midrst_pre_state", state_dbg, S_REQ_HI);
        check("midrst_pre_count", count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", req, 1'b0);
        check("midrst_count", count, 0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dout", dout, 12'h000);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        rst      = 1'b0;
        ack_mode = 0;
        in_valid = 1'b1;
        in_data  = 12'h123;
        tick();
        exp_q.push_back(12'h123);
        in_valid = 1'b0;
        check("post_rst_first_push", count, 1);
        wait_drained("post_rst");

        // Simultaneous push and pop with count = 1
        ack_mode  = 1;
        ack_force = 1'b0;
        push_word(12'h7E1);
        push_word(12'h7E2);
        ack_force = 1'b1;
        wait_state(S_REQ_LO, "simul_reach_req_lo");
        ack_force = 1'b0;
        wait_state(S_IDLE, "simul_reach_idle");
        check("simul_pre_count", count, 1);
        in_valid = 1'b1;
        in_data  = 12'h7E3;
        tick();
        exp_q.push_back(12'h7E3);
        in_valid = 1'b0;
        check("simul_count", count, 1);
        check("simul_state", state_dbg, S_SETUP);
        check("simul_load", dout, 12'h7E2);
        ack_mode = 0;
        wait_drained("simul");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
